regfile_cmd_master: RTL and testbench

- Hardware command initiator for the register-file command word interface (gpi0/gpo0).
- Takes a command request (opcode plus data) on a valid/ready handshake and formats the 32-bit command word: opcode [31:24], enable [23], data [22:0].
- Generates a clean enable rising edge, holds the word, samples the 32-bit response word, then releases enable.
- Optional wide mode reads 64-bit BER counters: it issues the requested opcode, then the BER_HIGH opcode, and returns both halves as one 64-bit response. Used in place of the soft micro for self-test and BER readout.

---
 rtl/regfile_cmd_pkg.sv | 32 +++
 rtl/regfile_cmd_master_if.sv | 26 ++
 rtl/regfile_cmd_master.sv | 133 +++++++++++++
 tb/tb_regfile_cmd_master.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_cmd_pkg.sv
// Shared definitions for the register-file command word interface:
// opcodes, command word field positions and the initiator FSM encoding.
package regfile_cmd_pkg;

    localparam logic [7:0] OP_RESET    = 8'h01;
    localparam logic [7:0] OP_EN_TX    = 8'h02;
    localparam logic [7:0] OP_EN_RX    = 8'h03;
    localparam logic [7:0] OP_PH_SEL   = 8'h04;
    localparam logic [7:0] OP_RUN_MEM  = 8'h05;
    localparam logic [7:0] OP_RD_MEM   = 8'h06;
    localparam logic [7:0] OP_IS_FULL  = 8'h07;
    localparam logic [7:0] OP_BER_S_I  = 8'h08;
    localparam logic [7:0] OP_BER_S_Q  = 8'h09;
    localparam logic [7:0] OP_BER_E_I  = 8'h0A;
    localparam logic [7:0] OP_BER_E_Q  = 8'h0B;
    localparam logic [7:0] OP_BER_HIGH = 8'h0C;

    localparam int CMD_MSB  = 31;
    localparam int CMD_LSB  = 24;
    localparam int ENB_BIT  = 23;
    localparam int DATA_MSB = 22;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/regfile_cmd_master_if.sv
// Request/response and register-file word signals of the command initiator.
// The master modport is the initiator's view; slave is the user/regfile side.
interface regfile_cmd_master_if;

    logic        i_req_valid;
    logic        o_req_ready;
    logic [7:0]  i_req_cmd;
    logic [22:0] i_req_data;
    logic        i_req_wide;
    logic [31:0] o_cmd_to_regs;
    logic [31:0] i_data_from_regs;
    logic        o_rsp_valid;
    logic [63:0] o_rsp_data;
    logic        o_busy;

    modport master (
        input  i_req_valid, i_req_cmd, i_req_data, i_req_wide, i_data_from_regs,
        output o_req_ready, o_cmd_to_regs, o_rsp_valid, o_rsp_data, o_busy
    );

    modport slave (
        output i_req_valid, i_req_cmd, i_req_data, i_req_wide, i_data_from_regs,
        input  o_req_ready, o_cmd_to_regs, o_rsp_valid, o_rsp_data, o_busy
    );

endinterface

// File: rtl/regfile_cmd_master.sv
// Command initiator for the register-file gpi0/gpo0 word interface: formats the
// command word, pulses enable, samples the response, optionally reads BER_HIGH too.
module regfile_cmd_master
    import regfile_cmd_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int NB_CNT      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_cmd_master_if.master bus
);

    generate
        if (HOLD_CYCLES < 3) begin : g_bad_hold
            $error("HOLD_CYCLES must be at least 3");
        end
        if (GAP_CYCLES < 1) begin : g_bad_gap
            $error("GAP_CYCLES must be at least 1");
        end
        if ((2 ** NB_CNT) <= HOLD_CYCLES || (2 ** NB_CNT) <= GAP_CYCLES) begin : g_bad_cnt
            $error("NB_CNT too narrow for HOLD_CYCLES/GAP_CYCLES");
        end
    endgenerate

    localparam logic [NB_CNT-1:0] HOLD_LOAD = NB_CNT'(HOLD_CYCLES - 1);
    localparam logic [NB_CNT-1:0] GAP_LOAD  = NB_CNT'(GAP_CYCLES - 1);

    state_t            state_reg,  state_next;
    logic [NB_CNT-1:0] cnt_reg,    cnt_next;
    logic              phase_reg,  phase_next;
    logic              wide_reg,   wide_next;
    logic [7:0]        cmd_reg,    cmd_next;
    logic [22:0]       data_reg,   data_next;
    logic [63:0]       rsp_reg,    rsp_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            wide_reg  <= 1'b0;
            cmd_reg   <= '0;
            data_reg  <= '0;
            rsp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
            wide_reg  <= wide_next;
            cmd_reg   <= cmd_next;
            data_reg  <= data_next;
            rsp_reg   <= rsp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        wide_next  = wide_reg;
        cmd_next   = cmd_reg;
        data_next  = data_reg;
        rsp_next   = rsp_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_req_valid) begin
                    cmd_next   = bus.i_req_cmd;
                    data_next  = bus.i_req_data;
                    wide_next  = bus.i_req_wide;
                    phase_next = 1'b0;
                    if (!bus.i_req_wide) begin
                        rsp_next[63:32] = '0;
                    end
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_next   = HOLD_LOAD;
                state_next = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (phase_reg) begin
                    rsp_next[63:32] = bus.i_data_from_regs;
                end else begin
                    rsp_next[31:0] = bus.i_data_from_regs;
                end
                cnt_next   = GAP_LOAD;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (wide_reg && !phase_reg) begin
                    // Second half of a 64-bit BER read: same handshake, high-word opcode.
                    phase_next = 1'b1;
                    cmd_next   = OP_BER_HIGH;
                    data_next  = '0;
                    state_next = ST_SETUP;
                end else begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    logic enb;
    assign enb = (state_reg == ST_ASSERT) || (state_reg == ST_SAMPLE);

    assign bus.o_cmd_to_regs[CMD_MSB:CMD_LSB] = cmd_reg;
    assign bus.o_cmd_to_regs[ENB_BIT]         = enb;
    assign bus.o_cmd_to_regs[DATA_MSB:0]      = data_reg;

    assign bus.o_req_ready = (state_reg == ST_IDLE);
    assign bus.o_busy      = (state_reg != ST_IDLE);
    assign bus.o_rsp_valid = (state_reg == ST_RESP);
    assign bus.o_rsp_data  = rsp_reg;

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed + random bench for regfile_cmd_master with a register-file responder
// and a cycle-level expected waveform derived from the command protocol.
module tb_regfile_cmd_master;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int PHASE_LEN = 1 + HOLD + 1 + GAP;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    logic [31:0] resp_lo = '0;
    logic [31:0] resp_hi = '0;
    int          hi_cnt  = 0;
    int          low_run = 0;
    int          min_gap = 1000;
    logic        seen_pulse = 1'b0;

    regfile_cmd_master_if bus ();

    regfile_cmd_master #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .NB_CNT     (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rsp_for(input logic [7:0] op);
        return (op == 8'h0C) ? resp_hi : resp_lo;
    endfunction

    // Register-file responder: garbage until enable has been high for two cycles.
    always @(negedge clock) begin
        if (bus.o_cmd_to_regs[23]) begin
            hi_cnt = hi_cnt + 1;
            if (hi_cnt == 1 && seen_pulse && low_run < min_gap) min_gap = low_run;
            low_run = 0;
            seen_pulse = 1'b1;
        end else begin
            hi_cnt = 0;
            low_run = low_run + 1;
        end
        bus.i_data_from_regs = (hi_cnt >= 2) ? rsp_for(bus.o_cmd_to_regs[31:24]) : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Expected command word k cycles after the accept edge (k = 1 .. n_cycles).
    function automatic logic [31:0] exp_word(input logic [7:0] cmd, input logic [22:0] data,
                                             input bit wide, input int k);
        int phases = wide ? 2 : 1;
        int p;
        int o;
        logic [7:0]  pc;
        logic [22:0] pd;
        logic        en;
        if (k > phases * PHASE_LEN) begin
            p = phases - 1;
            o = 0;
        end else begin
            p = (k - 1) / PHASE_LEN;
            o = (k - 1) % PHASE_LEN;
        end
        pc = (p == 1) ? 8'h0C : cmd;
        pd = (p == 1) ? 23'h0 : data;
        en = (k <= phases * PHASE_LEN) && (o >= 1) && (o <= HOLD + 1);
        return {pc, en, pd};
    endfunction

    // Issue one request; hold_valid keeps i_req_valid high for a back-to-back follow-up.
    task automatic do_txn(input logic [7:0] cmd, input logic [22:0] data, input bit wide,
                          input logic [31:0] lo, input logic [31:0] hi, input bit hold_valid);
        int n;
        int w;
        logic [63:0] exp_rsp;
        n = (wide ? 2 * PHASE_LEN : PHASE_LEN) + 1;
        bus.i_req_cmd   = cmd;
        bus.i_req_data  = data;
        bus.i_req_wide  = wide;
        bus.i_req_valid = 1'b1;
        w = 0;
        while (!bus.o_req_ready && w < 8) begin
            @(negedge clock);
            w++;
        end
        chk("ready_before_accept", {63'h0, bus.o_req_ready}, 64'h1);
        resp_lo = lo;
        resp_hi = hi;
        exp_rsp = wide ? {hi, rsp_for(cmd)} : {32'h0, rsp_for(cmd)};
        @(posedge clock);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (!hold_valid) begin
                bus.i_req_valid = (k == 1) ? 1'b0 : bus.i_req_valid;
                bus.i_req_cmd   = 8'($urandom);
                bus.i_req_data  = 23'($urandom);
                bus.i_req_wide  = 1'($urandom);
            end
            chk("cmd_word", {32'h0, bus.o_cmd_to_regs}, {32'h0, exp_word(cmd, data, wide, k)});
            chk("rsp_valid", {63'h0, bus.o_rsp_valid}, {63'h0, (k == n)});
            chk("busy", {63'h0, bus.o_busy}, 64'h1);
            chk("ready_busy", {63'h0, bus.o_req_ready}, 64'h0);
        end
        chk("rsp_data", bus.o_rsp_data, exp_rsp);
        $display("txn %0d cmd=%02h data=%06h wide=%0d rsp=%016h exp=%016h",
                 txn, cmd, data, wide, bus.o_rsp_data, exp_rsp);
        txn++;
    endtask

    initial begin
        logic [63:0] held;
        int rsp_seen;
        bus.i_req_valid      = 1'b0;
        bus.i_req_cmd        = '0;
        bus.i_req_data       = '0;
        bus.i_req_wide       = 1'b0;
        bus.i_data_from_regs = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_word", {32'h0, bus.o_cmd_to_regs}, 64'h0);
        chk("reset_rsp_valid", {63'h0, bus.o_rsp_valid}, 64'h0);
        chk("reset_rsp_data", bus.o_rsp_data, 64'h0);
        chk("reset_busy", {63'h0, bus.o_busy}, 64'h0);
        chk("reset_ready", {63'h0, bus.o_req_ready}, 64'h1);

        // Directed: narrow write, narrow read, wide BER read.
        do_txn(8'h02, 23'h000001, 1'b0, 32'h1111_2222, 32'h3333_4444, 1'b0);
        @(negedge clock);
        chk("idle_word_hold", {32'h0, bus.o_cmd_to_regs}, 64'h0200_0001);
        chk("idle_ready", {63'h0, bus.o_req_ready}, 64'h1);
        do_txn(8'h07, 23'h000000, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        repeat (2) @(negedge clock);
        do_txn(8'h08, 23'h000000, 1'b1, 32'h89AB_CDEF, 32'h0123_4567, 1'b0);
        // Response must hold across idle cycles until the next accept.
        held = bus.o_rsp_data;
        repeat (3) @(negedge clock);
        chk("rsp_hold", bus.o_rsp_data, 64'h0123_4567_89AB_CDEF);

        // Narrow after wide must clear the upper half.
        do_txn(8'h0A, 23'h55AA55, 1'b0, 32'hCAFE_F00D, 32'hDEAD_0001, 1'b0);

        // Back-to-back with valid held high.
        seen_pulse = 1'b0;
        min_gap = 1000;
        do_txn(8'h03, 23'h000123, 1'b0, 32'hA5A5_0001, 32'h0, 1'b1);
        do_txn(8'h05, 23'h000456, 1'b0, 32'hA5A5_0002, 32'h0, 1'b0);
        chk("b2b_min_gap_ok", {63'h0, (min_gap >= GAP + 1)}, 64'h1);

        // Random requests, including wide and the BER_HIGH opcode itself.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] c;
            c = (i == 3) ? 8'h0C : 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            do_txn(c, 23'($urandom), 1'($urandom), $urandom, $urandom, 1'b0);
        end

        // Reset in the middle of ASSERT.
        @(negedge clock);
        bus.i_req_cmd   = 8'h09;
        bus.i_req_data  = 23'h000777;
        bus.i_req_wide  = 1'b1;
        bus.i_req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.i_req_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_reset_enable", {63'h0, bus.o_cmd_to_regs[23]}, 64'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_word", {32'h0, bus.o_cmd_to_regs}, 64'h0);
        chk("midreset_busy", {63'h0, bus.o_busy}, 64'h0);
        chk("midreset_ready", {63'h0, bus.o_req_ready}, 64'h1);
        chk("midreset_rsp_data", bus.o_rsp_data, 64'h0);
        reset = 1'b0;
        rsp_seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (bus.o_rsp_valid) rsp_seen++;
        end
        chk("no_rsp_after_reset", 64'(rsp_seen), 64'h0);
        chk("idle_after_reset", {63'h0, bus.o_busy}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
